ascii_countdown: RTL and testbench

Parametrised countdown timer over DIGITS decimal digits held as ASCII characters. It loads an ASCII preset, decrements by one on each `tick` strobe while running, supports pause, and flags expiry with a one-cycle `done` pulse. After every change of value it streams the current count, most significant digit first, as ASCII bytes over a valid/ready port for the display/UART path. It replaces the fixed two-digit counter/change_state pair in the lab05 timer path.

---
 rtl/ascii_countdown_pkg.sv | 27 ++
 rtl/bcd_digit_dec.sv | 26 ++
 rtl/ascii_countdown.sv | 155 +++++++++++++++
 tb/tb_ascii_countdown.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_countdown_pkg.sv
// Shared types and ASCII/BCD helpers for the ascii_countdown timer.
package ascii_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [3:0] BCD_NINE   = 4'd9;

  function automatic logic is_ascii_digit(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
  endfunction

  // '0'..'9' carry their value in the low nibble; anything else loads as 0.
  function automatic logic [3:0] ascii_to_bcd(input logic [7:0] c);
    return is_ascii_digit(c) ? c[3:0] : 4'd0;
  endfunction

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    return ASCII_ZERO | {4'h0, d};
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a down-counter; borrow_in acts as the decrement enable.
module bcd_digit_dec
  import ascii_countdown_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  always_ff @(posedge clock) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_value;
    end else if (borrow_in) begin
      digit <= (digit == 4'd0) ? BCD_NINE : digit - 4'd1;
    end
  end

  assign borrow_out = borrow_in & (digit == 4'd0);

endmodule

// File: rtl/ascii_countdown.sv
// DIGITS-digit ASCII countdown timer with pause, done pulse and a valid/ready digit stream.
// Optional auto-reload at expiry is enabled by defining ASCII_COUNTDOWN_AUTO_RELOAD_EN.
module ascii_countdown
  import ascii_countdown_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [8*DIGITS-1:0] preset,
  input  logic                load,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [8*DIGITS-1:0] count_ascii,
  output logic [7:0]          ascii_out,
  output logic                ascii_valid,
  input  logic                ascii_ready,
  output logic                done,
  output logic                running,
  output logic                bad_digit,
  output state_t              fsm_state
);

  localparam int CW = $clog2(DIGITS + 1);

  state_t                state, next_state;
  logic [4*DIGITS-1:0]   count_bcd;
  logic [4*DIGITS-1:0]   load_bcd;
  logic [4*DIGITS-1:0]   digit_value;
  logic                  preset_bad;
  logic                  count_zero, count_one;
  logic                  tick_acc, dec_en, reload, digit_load, update_req;
  logic                  preset_zero;
  logic [DIGITS:0]       borrow;
  logic                  unused_borrow;

  always_comb begin
    load_bcd   = '0;
    preset_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      load_bcd[4*i +: 4] = ascii_to_bcd(preset[8*i +: 8]);
      preset_bad         = preset_bad | !is_ascii_digit(preset[8*i +: 8]);
    end
  end

  assign count_zero = (count_bcd == '0);
  assign count_one  = (count_bcd == (4*DIGITS)'(1));
  assign tick_acc   = (state == ST_RUN) && tick && !pause && !load;
  assign dec_en     = tick_acc && !count_zero;

`ifdef ASCII_COUNTDOWN_AUTO_RELOAD_EN
  logic [4*DIGITS-1:0] preset_bcd;

  always_ff @(posedge clock) begin
    if (reset) begin
      preset_bcd <= '0;
    end else if (load) begin
      preset_bcd <= load_bcd;
    end
  end

  // A RUN state resting at zero has already pulsed done; its next tick restarts the period.
  assign preset_zero = (preset_bcd == '0);
  assign reload      = tick_acc && count_zero;
  assign digit_value = load ? load_bcd : preset_bcd;
`else
  assign preset_zero = 1'b1;
  assign reload      = 1'b0;
  assign digit_value = load_bcd;
`endif

  assign digit_load = load | reload;
  assign update_req = load | dec_en | reload;
  assign borrow[0]  = dec_en;
  assign unused_borrow = borrow[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_dec u_digit (
      .clock      (clock),
      .reset      (reset),
      .load       (digit_load),
      .load_value (digit_value[4*i +: 4]),
      .borrow_in  (borrow[i]),
      .digit      (count_bcd[4*i +: 4]),
      .borrow_out (borrow[i+1])
    );
    assign count_ascii[8*i +: 8] = bcd_to_ascii(count_bcd[4*i +: 4]);
  end

  always_comb begin
    next_state = state;
    if (load) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start && !count_zero) next_state = ST_RUN;
        ST_RUN:     if (dec_en && count_one && preset_zero) next_state = ST_EXPIRED;
        ST_EXPIRED: next_state = ST_EXPIRED;
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      state     <= next_state;
      done      <= dec_en && count_one;
      bad_digit <= bad_digit | (load & preset_bad);
    end
  end

  assign running   = (state == ST_RUN);
  assign fsm_state = state;

  // Stream port: a byte transfers on a rising edge where ascii_valid && ascii_ready;
  // while valid is high and ready low, ascii_out and ascii_valid hold unchanged.
  logic                req_q, pending;
  logic [8*DIGITS-1:0] snap;
  logic [CW-1:0]       left;

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q       <= 1'b0;
      pending     <= 1'b0;
      ascii_valid <= 1'b0;
      snap        <= '0;
      left        <= '0;
    end else begin
      req_q <= update_req;
      if (!ascii_valid) begin
        if (req_q || pending) begin
          snap        <= count_ascii;
          left        <= CW'(DIGITS);
          ascii_valid <= 1'b1;
          pending     <= 1'b0;
        end
      end else begin
        if (req_q) pending <= 1'b1;
        if (ascii_ready) begin
          snap <= snap << 8;
          left <= left - CW'(1);
          if (left == CW'(1)) ascii_valid <= 1'b0;
        end
      end
    end
  end

  assign ascii_out = ascii_valid ? snap[8*DIGITS-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_ascii_countdown.sv
// Directed self-checking bench for ascii_countdown with DIGITS=2.
module tb_ascii_countdown;
  import ascii_countdown_pkg::*;

  localparam int DIGITS = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [8*DIGITS-1:0] preset;
  logic                load, start, pause, tick;
  logic [8*DIGITS-1:0] count_ascii;
  logic [7:0]          ascii_out;
  logic                ascii_valid, ascii_ready;
  logic                done, running, bad_digit;
  state_t              fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  ascii_countdown #(.DIGITS(DIGITS)) dut (
    .clock       (clock),
    .reset       (reset),
    .preset      (preset),
    .load        (load),
    .start       (start),
    .pause       (pause),
    .tick        (tick),
    .count_ascii (count_ascii),
    .ascii_out   (ascii_out),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .done        (done),
    .running     (running),
    .bad_digit   (bad_digit),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_load(input logic [8*DIGITS-1:0] v);
    preset = v;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic drain();
    ascii_ready = 1'b1;
    repeat (8) step();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ascii_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    n_checks++; if (count_ascii !== 16'h3030) begin n_fail++; $display("FAIL reset_count got %h want %h", count_ascii, 16'h3030); end
    n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", fsm_state, ST_IDLE); end
    n_checks++; if (ascii_valid !== 1'b0 || ascii_out !== 8'h00) begin n_fail++; $display("FAIL reset_stream got valid=%b out=%h want 0/00", ascii_valid, ascii_out); end
    n_checks++; if (done !== 1'b0 || running !== 1'b0 || bad_digit !== 1'b0) begin n_fail++; $display("FAIL reset_flags got done=%b run=%b bad=%b want 000", done, running, bad_digit); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_countdown();
    logic [15:0] exp_v;
    int done_cnt;
    done_cnt = 0;
    pulse_load(16'h3132);
    n_checks++; if (count_ascii !== 16'h3132) begin n_fail++; $display("FAIL load12 got %h want 3132", count_ascii); end
    pulse_start();
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running got %b want 1", running); end
    for (int e = 11; e >= 0; e--) begin
      pulse_tick();
      exp_v = {8'h30 + 8'(e / 10), 8'h30 + 8'(e % 10)};
      n_checks++; if (count_ascii !== exp_v) begin n_fail++; $display("FAIL count_step%0d got %h want %h", e, count_ascii, exp_v); end
      n_checks++; if (done !== (e == 0)) begin n_fail++; $display("FAIL done_step%0d got %b want %b", e, done, (e == 0)); end
      if (done === 1'b1) done_cnt++;
      step();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width%0d got %b want 0", e, done); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL done_count got %0d want 1", done_cnt); end
    n_checks++; if (fsm_state !== ST_EXPIRED || running !== 1'b0) begin n_fail++; $display("FAIL expired_state got %0d run=%b want %0d run=0", fsm_state, running, ST_EXPIRED); end
    pulse_tick();
    pulse_tick();
    pulse_start();
    n_checks++; if (count_ascii !== 16'h3030 || done !== 1'b0) begin n_fail++; $display("FAIL expired_hold got %h done=%b want 3030 done=0", count_ascii, done); end
    n_checks++; if (fsm_state !== ST_EXPIRED) begin n_fail++; $display("FAIL expired_start got %0d want %0d", fsm_state, ST_EXPIRED); end
    pulse_load(16'h3030);
    pulse_start();
    n_checks++; if (fsm_state !== ST_IDLE || running !== 1'b0) begin n_fail++; $display("FAIL start_zero got %0d run=%b want IDLE run=0", fsm_state, running); end
    drain();
  endtask

  task automatic test_borrow_stream();
    bit ok;
    pulse_load(16'h3130);
    pulse_start();
    drain();
    ascii_ready = 1'b0;
    pulse_tick();
    n_checks++; if (count_ascii !== 16'h3039) begin n_fail++; $display("FAIL borrow got %h want 3039", count_ascii); end
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL borrow_stream_start got valid=0 want 1"); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (ascii_valid !== 1'b1 || ascii_out !== 8'h30) begin n_fail++; $display("FAIL stall_b0_%0d got v=%b %h want 1 30", k, ascii_valid, ascii_out); end
      step();
    end
    ascii_ready = 1'b1;
    step();
    ascii_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (ascii_valid !== 1'b1 || ascii_out !== 8'h39) begin n_fail++; $display("FAIL stall_b1_%0d got v=%b %h want 1 39", k, ascii_valid, ascii_out); end
      step();
    end
    ascii_ready = 1'b1;
    step();
    n_checks++; if (ascii_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end got valid=%b want 0", ascii_valid); end
  endtask

  task automatic test_pause();
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pulse_tick();
      n_checks++; if (count_ascii !== 16'h3039 || running !== 1'b1) begin n_fail++; $display("FAIL pause_%0d got %h run=%b want 3039 run=1", k, count_ascii, running); end
    end
    pause = 1'b0;
    pulse_tick();
    n_checks++; if (count_ascii !== 16'h3038 || running !== 1'b1) begin n_fail++; $display("FAIL unpause got %h run=%b want 3038 run=1", count_ascii, running); end
    drain();
  endtask

  task automatic test_load_priority();
    pulse_load(16'h3033);
    pulse_start();
    preset = 16'h3038;
    load = 1'b1; start = 1'b1; tick = 1'b1;
    step();
    load = 1'b0; start = 1'b0; tick = 1'b0;
    n_checks++; if (count_ascii !== 16'h3038) begin n_fail++; $display("FAIL load_prio_count got %h want 3038", count_ascii); end
    n_checks++; if (fsm_state !== ST_IDLE || running !== 1'b0) begin n_fail++; $display("FAIL load_prio_state got %0d run=%b want IDLE run=0", fsm_state, running); end
    drain();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    pulse_load(16'h3035);
    pulse_start();
    drain();
    ascii_ready = 1'b0;
    pulse_tick();
    wait_valid(ok);
    n_checks++; if (!ok || ascii_out !== 8'h30) begin n_fail++; $display("FAIL b2b_first got ok=%b %h want 1 30", ok, ascii_out); end
    pulse_tick();
    n_checks++; if (ascii_out !== 8'h30 || ascii_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_stable got v=%b %h want 1 30", ascii_valid, ascii_out); end
    pulse_tick();
    n_checks++; if (count_ascii !== 16'h3032) begin n_fail++; $display("FAIL b2b_count got %h want 3032", count_ascii); end
    exp_q.push_back(8'h30); exp_q.push_back(8'h34);
    exp_q.push_back(8'h30); exp_q.push_back(8'h32);
    ascii_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (ascii_valid) got_q.push_back(ascii_out);
      step();
    end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== e) begin
        n_fail++;
        $display("FAIL b2b_byte%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, e);
      end
    end
  endtask

  task automatic test_bad_digit();
    pulse_load(16'h3541);
    n_checks++; if (count_ascii !== 16'h3530 || bad_digit !== 1'b1) begin n_fail++; $display("FAIL bad_load got %h bad=%b want 3530 bad=1", count_ascii, bad_digit); end
    pulse_load(16'h3037);
    n_checks++; if (count_ascii !== 16'h3037 || bad_digit !== 1'b1) begin n_fail++; $display("FAIL bad_sticky got %h bad=%b want 3037 bad=1", count_ascii, bad_digit); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (bad_digit !== 1'b0 || count_ascii !== 16'h3030) begin n_fail++; $display("FAIL bad_reset got bad=%b %h want 0 3030", bad_digit, count_ascii); end
    step();
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    ascii_ready = 1'b0;
    pulse_load(16'h3334);
    wait_valid(ok);
    n_checks++; if (!ok || ascii_out !== 8'h33) begin n_fail++; $display("FAIL rst_stream_pre got ok=%b %h want 1 33", ok, ascii_out); end
    reset = 1'b1;
    step();
    n_checks++; if (ascii_valid !== 1'b0 || ascii_out !== 8'h00) begin n_fail++; $display("FAIL rst_stream got v=%b %h want 0 00", ascii_valid, ascii_out); end
    reset = 1'b0;
    ascii_ready = 1'b1;
    step();
  endtask

`ifdef ASCII_COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [15:0] exp_v [5];
    logic        exp_d [5];
    exp_v = '{16'h3031, 16'h3030, 16'h3032, 16'h3031, 16'h3030};
    exp_d = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    pulse_load(16'h3032);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      pulse_tick();
      n_checks++; if (count_ascii !== exp_v[k] || done !== exp_d[k]) begin n_fail++; $display("FAIL auto_%0d got %h done=%b want %h done=%b", k, count_ascii, done, exp_v[k], exp_d[k]); end
      step();
    end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL auto_running got %b want 1", running); end
    drain();
  endtask
`endif

  initial begin
    reset = 1'b1; preset = '0; load = 1'b0; start = 1'b0;
    pause = 1'b0; tick = 1'b0; ascii_ready = 1'b1;
    test_reset();
    test_countdown();
    test_borrow_stream();
    test_pause();
    test_load_priority();
    test_back_to_back();
    test_bad_digit();
    test_reset_mid_stream();
`ifdef ASCII_COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
